// File: rtl/rf_wb_if.sv
// Write-back bundle: load issue, ALU/load/link sources, hazard query and
// register-file write side. master = pipeline/driver, slave = rf_writeback.
interface rf_wb_if #(parameter int WIDTH = 32);
  logic             iss_valid;
  logic             iss_is_load;
  logic [4:0]       iss_wa;
  logic             iss_ready;
  logic             alu_valid;
  logic [4:0]       alu_wa;
  logic [WIDTH-1:0] alu_wd;
  logic             ld_valid;
  logic [WIDTH-1:0] ld_wd;
  logic             ld_ready;
  logic             jal_valid;
  logic [WIDTH-1:0] jal_pc;
  logic [4:0]       ra0;
  logic [4:0]       ra1;
  logic             busy0;
  logic             busy1;
  logic [4:0]       wa;
  logic             we;
  logic [WIDTH-1:0] wd;
  logic             alr;
  logic [WIDTH-1:0] pc;

  modport master (
    output iss_valid, iss_is_load, iss_wa, alu_valid, alu_wa, alu_wd,
           ld_valid, ld_wd, jal_valid, jal_pc, ra0, ra1,
    input  iss_ready, ld_ready, busy0, busy1, wa, we, wd, alr, pc
  );

  modport slave (
    input  iss_valid, iss_is_load, iss_wa, alu_valid, alu_wa, alu_wd,
           ld_valid, ld_wd, jal_valid, jal_pc, ra0, ra1,
    output iss_ready, ld_ready, busy0, busy1, wa, we, wd, alr, pc
  );
endinterface

// File: rtl/rf_writeback.sv
// Register-file write-back arbiter: ALU first, then held load, plus link write.
// Optional RF_WB_BYPASS_EN lets an accepted load skip the hold register.
module rf_writeback #(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   rst_n,
  rf_wb_if.slave bus
);

  logic [4:0]       tag_q [4];
  logic [3:0]       tag_vld;
  logic [1:0]       rd_ptr;
  logic [1:0]       wr_ptr;
  logic [2:0]       count;
  logic             hold_vld;
  logic [4:0]       hold_wa;
  logic [WIDTH-1:0] hold_wd;
  logic             push;
  logic             pop;
  logic             sel_vld;
  logic             hold_take;
  logic             bypass;
  logic [4:0]       sel_wa;
  logic [WIDTH-1:0] sel_wd;
  logic             we_nxt;
  logic             we_q;
  logic             alr_q;
  logic [4:0]       wa_q;
  logic [WIDTH-1:0] wd_q;
  logic [WIDTH-1:0] pc_q;
  logic             busy0;
  logic             busy1;

  assign bus.iss_ready = (count != 3'd4);
  assign bus.ld_ready  = !hold_vld && (count != 3'd0);
  assign push = bus.iss_valid && bus.iss_is_load && bus.iss_ready;
  assign pop  = bus.ld_valid && bus.ld_ready;

  // push and pop never target the same slot: that needs count 0 or 4
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) tag_q[i] <= '0;
      tag_vld <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr]   <= bus.iss_wa;
        tag_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 2'd1;
      end
      if (pop) begin
        tag_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    sel_vld   = 1'b0;
    sel_wa    = '0;
    sel_wd    = '0;
    hold_take = 1'b0;
    bypass    = 1'b0;
    if (bus.alu_valid) begin
      sel_vld = 1'b1;
      sel_wa  = bus.alu_wa;
      sel_wd  = bus.alu_wd;
    end else if (hold_vld) begin
      sel_vld   = 1'b1;
      sel_wa    = hold_wa;
      sel_wd    = hold_wd;
      hold_take = 1'b1;
`ifdef RF_WB_BYPASS_EN
    end else if (pop) begin
      sel_vld = 1'b1;
      sel_wa  = tag_q[rd_ptr];
      sel_wd  = bus.ld_wd;
      bypass  = 1'b1;
`endif
    end
  end

  // r0 is never written; a same-cycle link write owns r31
  assign we_nxt = sel_vld && (sel_wa != 5'd0) && !(bus.jal_valid && sel_wa == 5'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld <= 1'b0;
      hold_wa  <= '0;
      hold_wd  <= '0;
    end else if (pop && !bypass) begin
      hold_vld <= 1'b1;
      hold_wa  <= tag_q[rd_ptr];
      hold_wd  <= bus.ld_wd;
    end else if (hold_take) begin
      hold_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      alr_q <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
      pc_q  <= '0;
    end else begin
      we_q  <= we_nxt;
      alr_q <= bus.jal_valid;
      if (sel_vld) begin
        wa_q <= sel_wa;
        wd_q <= sel_wd;
      end
      if (bus.jal_valid) pc_q <= bus.jal_pc;
    end
  end

  always_comb begin
    busy0 = 1'b0;
    busy1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (tag_vld[i] && tag_q[i] == bus.ra0) busy0 = 1'b1;
      if (tag_vld[i] && tag_q[i] == bus.ra1) busy1 = 1'b1;
    end
    if (hold_vld && hold_wa == bus.ra0) busy0 = 1'b1;
    if (hold_vld && hold_wa == bus.ra1) busy1 = 1'b1;
    if (bus.ra0 == 5'd0) busy0 = 1'b0;
    if (bus.ra1 == 5'd0) busy1 = 1'b0;
  end

  assign bus.busy0 = busy0;
  assign bus.busy1 = busy1;
  assign bus.we    = we_q;
  assign bus.wa    = wa_q;
  assign bus.wd    = wd_q;
  assign bus.alr   = alr_q;
  assign bus.pc    = pc_q;

endmodule

// File: doc/rf_writeback.md
RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 SHALL have parameter: WIDTH, 32, data width of register file word.
REQ-002 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: iss_valid  in  1  instruction issued this cycle.
REQ-005 SHALL have ports: iss_is_load  in  1  issued instruction is a load.
REQ-006 SHALL have ports: iss_wa  in  5  destination register of issued load.
REQ-007 SHALL have ports: iss_ready  out  1  load tag queue can accept (count<4).
REQ-008 SHALL have ports: alu_valid  in  1  ALU result valid; alu_wa  in  5; alu_wd  in  WIDTH.
REQ-009 SHALL have ports: ld_valid  in  1  load data return; ld_wd  in  WIDTH; ld_ready  out  1.
REQ-010 SHALL have ports: jal_valid  in  1  link write request; jal_pc  in  WIDTH  PC of jump.
REQ-011 SHALL have ports: ra0, ra1  in  5  hazard query addresses; busy0, busy1  out  1  load pending to ra0/ra1.
REQ-012 SHALL have ports: wa  out  5; we  out  1; wd  out  WIDTH; alr  out  1; pc  out  WIDTH -- register-file write side.

Function
REQ-013 SHALL keep a 4-entry in-order FIFO of load destination tags; push on iss_valid&iss_is_load&iss_ready.
REQ-014 SHALL drive iss_ready = (tag count < 4); issue with iss_ready low SHALL not push (issuer stalls).
REQ-015 SHALL drive ld_ready = hold register empty AND tag FIFO non-empty; ld_valid&ld_ready pops the head tag and pairs it with ld_wd.
REQ-016 SHALL ignore ld_valid while ld_ready low (no pop, no write).
REQ-017 SHALL register all write-side outputs: one write per cycle on wa/we/wd.
REQ-018 SHALL give ALU priority: alu_valid at edge N -> we=1, wa=alu_wa, wd=alu_wd after edge N+1.
REQ-019 SHALL hold a paired load (tag,data) in a 1-entry hold register and emit it in the first cycle with alu_valid low; held entry SHALL never be lost or duplicated.
REQ-020 SHALL force we=0 when selected destination is 0 (hold/FIFO entry still consumed).
REQ-021 SHALL drive alr=1, pc=jal_pc one cycle after jal_valid, independent of we.
REQ-022 SHALL, when alr and a we write to wa=31 coincide, force we=0 (link write wins, other write dropped).
REQ-023 SHALL drive busy0/busy1 combinationally = 1 if ra matches any valid FIFO tag or the valid hold tag, ra!=0.
REQ-024 SHALL allow push and pop in the same cycle at any count, including push at count 3 with pop.
REQ-025 SHALL deassert we/alr in cycles with nothing to write.

Reset
REQ-026 SHALL on rst_n low immediately clear FIFO, hold register, we, alr, wa, wd, pc to 0.
REQ-027 SHALL after reset drive iss_ready=1, ld_ready=0, busy0=busy1=0.
REQ-028 SHALL discard outstanding loads on reset mid-operation; no write emitted after release.

Configuration
REQ-029 SHALL, with RF_WB_BYPASS_EN defined, route accepted load data directly to the output register when hold empty and alu_valid low in the accepting cycle (latency 1).
REQ-030 SHALL, without RF_WB_BYPASS_EN, always pass load data through the hold register (minimum latency 2).

Verification
REQ-031 SHALL cover: alu_valid, alu_wa=5, alu_wd=0x1234 -> next cycle we=1, wa=5, wd=0x1234.
REQ-032 SHALL cover: issue load wa=7, then ld_valid ld_wd=0xAA -> busy=1 for ra0=7 until write; we/wa=7/wd=0xAA after 2 cycles (1 with RF_WB_BYPASS_EN).
REQ-033 SHALL cover: 4 load issues -> iss_ready=0; 5th issue ignored; one return -> iss_ready=1.
REQ-034 SHALL cover: load held plus alu_valid 3 consecutive cycles -> ALU writes first, load written in 4th cycle, ld_ready=0 meanwhile.
REQ-035 SHALL cover: jal_valid jal_pc=0x100 with alu_wa=31 same cycle -> alr=1, pc=0x100, we=0.
REQ-036 SHALL cover: rst_n low with 2 loads pending -> outputs 0 immediately, no write after release, ld_ready=0.
